// File: rtl/chimera_pkg.sv
// Chimera shared definitions.
// Cluster sequencer constants, register offsets, bus types.
package chimera_pkg;

  localparam int ExtClusters = 5;

  localparam int ClusterSeqDelayDefault = 16;
  localparam int ClusterSeqCntWidth = 8;

  localparam logic [11:0] ClusterCtrlOffset = 12'h000;
  localparam logic [11:0] ClusterStatusOffset = 12'h040;
  localparam logic [11:0] ClusterDelayOffset = 12'h044;

  typedef enum logic [1:0] {
    SeqOff,
    SeqClkOn,
    SeqRun,
    SeqRstOn
  } cluster_seq_e;

  typedef struct packed {
    logic [31:0] addr;
    logic write;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic valid;
  } chimera_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic error;
    logic ready;
  } chimera_reg_rsp_t;

endpackage

// File: rtl/chimera_cluster_seq.sv
// Single-cluster power sequencer.
// Orders clock enable before reset release, reset before clock gate.
module chimera_cluster_seq
  import chimera_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic [ClusterSeqCntWidth-1:0] delay,
  output logic clkEn,
  output logic clusterRst,
  output logic busy,
  output logic running
);

  cluster_seq_e state;
  cluster_seq_e stateNext;
  logic [ClusterSeqCntWidth-1:0] cnt;
  logic [ClusterSeqCntWidth-1:0] cntNext;
  logic clkEnNext;
  logic rstNext;
  logic busyNext;
  logic runNext;

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SeqOff;
      cnt <= '0;
      clkEn <= 1'b0;
      clusterRst <= 1'b1;
      busy <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      clkEn <= clkEnNext;
      clusterRst <= rstNext;
      busy <= busyNext;
      running <= runNext;
    end
  end

  // Next state; a started phase always runs to completion.
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    unique case (state)
      SeqOff: begin
        if (req) begin
          stateNext = SeqClkOn;
          cntNext = delay;
        end
      end
      SeqClkOn: begin
        if (cnt != '0) begin
          cntNext = cnt - ClusterSeqCntWidth'(1);
        end else begin
          stateNext = req ? SeqRun : SeqOff;
        end
      end
      SeqRun: begin
        if (!req) begin
          stateNext = SeqRstOn;
          cntNext = delay;
        end
      end
      SeqRstOn: begin
        if (cnt != '0) begin
          cntNext = cnt - ClusterSeqCntWidth'(1);
        end else if (req) begin
          stateNext = SeqClkOn;
          cntNext = delay;
        end else begin
          stateNext = SeqOff;
        end
      end
      default: begin
        stateNext = SeqOff;
      end
    endcase
  end

  // Output decode of the next state, so outputs come straight from flops.
  always_comb begin
    clkEnNext = (stateNext != SeqOff);
    rstNext = (stateNext != SeqRun);
    busyNext = (stateNext == SeqClkOn) || (stateNext == SeqRstOn);
    runNext = (stateNext == SeqRun);
  end

endmodule

// File: rtl/chimera_cluster_ctrl.sv
// Chimera cluster control register window.
// Per-cluster power request bits and clock/reset sequencers.
module chimera_cluster_ctrl
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters = ExtClusters,
  parameter type reg_req_t = chimera_pkg::chimera_reg_req_t,
  parameter type reg_rsp_t = chimera_pkg::chimera_reg_rsp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic [NumClusters-1:0] cluster_clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic busy_o
);

  logic [NumClusters-1:0] req;
  logic [NumClusters-1:0] clkEn;
  logic [NumClusters-1:0] clRst;
  logic [NumClusters-1:0] seqBusy;
  logic [NumClusters-1:0] seqRun;
  logic [ClusterSeqCntWidth-1:0] delay;

  logic [11:0] offset;
  logic [NumClusters-1:0] ctrlHit;
  logic statusHit;
  logic delayHit;
  logic decErr;
  logic wrEn;
  logic [31:0] rdataInt;
  logic unusedBits;

  assign offset = reg_req_i.addr[11:0];
  assign unusedBits = ^{reg_req_i.addr[31:12],
                        reg_req_i.wdata[31:8],
                        reg_req_i.wstrb[3:1]};

  // Address decode; STATUS is read-only so a write to it is an error.
  always_comb begin
    ctrlHit = '0;
    for (int i = 0; i < NumClusters; i++) begin
      ctrlHit[i] = (offset == ClusterCtrlOffset + 12'(4 * i));
    end
    statusHit = (offset == ClusterStatusOffset);
    delayHit = (offset == ClusterDelayOffset);
    decErr = !((|ctrlHit) || statusHit || delayHit) ||
             (statusHit && reg_req_i.write);
    wrEn = reg_req_i.valid && reg_req_i.write &&
           reg_req_i.wstrb[0] && !decErr;
  end

  // Read data mux from the register and sequencer flops.
  always_comb begin
    rdataInt = '0;
    for (int i = 0; i < NumClusters; i++) begin
      if (ctrlHit[i]) begin
        rdataInt = {28'b0, seqBusy[i], clRst[i], clkEn[i], req[i]};
      end
    end
    if (statusHit) begin
      rdataInt[NumClusters-1:0] = seqRun;
    end
    if (delayHit) begin
      rdataInt[ClusterSeqCntWidth-1:0] = delay;
    end
  end

  // Single-cycle response; all zero when no request is pending.
  always_comb begin
    reg_rsp_o = '0;
    if (reg_req_i.valid) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.error = decErr;
      reg_rsp_o.rdata = decErr ? 32'b0 : rdataInt;
    end
  end

  // Request bits and DELAY register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req <= '0;
      delay <= ClusterSeqCntWidth'(ClusterSeqDelayDefault);
    end else if (wrEn) begin
      for (int i = 0; i < NumClusters; i++) begin
        if (ctrlHit[i]) begin
          req[i] <= reg_req_i.wdata[0];
        end
      end
      if (delayHit) begin
        delay <= reg_req_i.wdata[ClusterSeqCntWidth-1:0];
      end
    end
  end

  for (genvar g = 0; g < NumClusters; g++) begin : gSeq
    chimera_cluster_seq uSeq (
      .clk(clk_i),
      .rst(rst_i),
      .req(req[g]),
      .delay(delay),
      .clkEn(clkEn[g]),
      .clusterRst(clRst[g]),
      .busy(seqBusy[g]),
      .running(seqRun[g])
    );
  end

  assign cluster_clk_en_o = clkEn;
  assign cluster_rst_o = clRst;
  assign busy_o = |seqBusy;

endmodule
